// File: rtl/cell_axi_pkg.sv
// Shared AXI-lite definitions for the cell_axilite family.
// Holds the AXI response codes and the parameter loader state encoding.
package cell_axi_pkg;

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_EXOKAY = 2'b01;
    localparam logic [1:0] RESP_SLVERR = 2'b10;
    localparam logic [1:0] RESP_DECERR = 2'b11;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_FETCH,
        ST_ISSUE,
        ST_RESP,
        ST_FIN
    } loader_state_e;

endpackage

// File: rtl/cell_axilite_param_loader_if.sv
// AXI4-Lite write channels (AW, W, B) between the parameter loader and a
// register-file slave.
//   master: drives awaddr/awvalid, wdata/wstrb/wvalid, bready
//   slave : drives awready, wready, bresp/bvalid
interface cell_axilite_param_loader_if #(
    parameter int ADDR_SIZE  = 32,
    parameter int DATA_WIDTH = 32
);
    localparam int NUM_STROBE = DATA_WIDTH / 8;

    logic [ADDR_SIZE-1:0]  awaddr;
    logic                  awvalid;
    logic                  awready;
    logic [DATA_WIDTH-1:0] wdata;
    logic [NUM_STROBE-1:0] wstrb;
    logic                  wvalid;
    logic                  wready;
    logic [1:0]            bresp;
    logic                  bvalid;
    logic                  bready;

    modport master (
        output awaddr, awvalid, wdata, wstrb, wvalid, bready,
        input  awready, wready, bresp, bvalid
    );

    modport slave (
        input  awaddr, awvalid, wdata, wstrb, wvalid, bready,
        output awready, wready, bresp, bvalid
    );

endinterface

// File: rtl/cell_axilite_param_loader.sv
// AXI4-Lite write initiator: on start, streams word_count words from a
// valid/ready source into consecutive word addresses starting at base_addr,
// one single-beat write at a time. A non-OKAY response aborts the command
// and records the failing address.
// Ports:
//   aclk, aresetn            clock, async active-low reset
//   start/base_addr/word_count  command (sampled only in IDLE)
//   s_data/s_valid/s_ready   word source
//   busy/done/err/err_addr   status (err sticky until next start)
//   axi                      AXI-lite write channels (master side)
module cell_axilite_param_loader
    import cell_axi_pkg::*;
#(
    parameter int ADDR_SIZE  = 32,
    parameter int DATA_WIDTH = 32,
    parameter int CNT_W      = 8
) (
    input  logic                  aclk,
    input  logic                  aresetn,
    input  logic                  start,
    input  logic [ADDR_SIZE-1:0]  base_addr,
    input  logic [CNT_W-1:0]      word_count,
    input  logic [DATA_WIDTH-1:0] s_data,
    input  logic                  s_valid,
    output logic                  s_ready,
    output logic                  busy,
    output logic                  done,
    output logic                  err,
    output logic [ADDR_SIZE-1:0]  err_addr,
    cell_axilite_param_loader_if.master axi
);

    localparam int NUM_STROBE = DATA_WIDTH / 8;

    loader_state_e         state, state_d;
    logic [ADDR_SIZE-1:0]  addr;
    logic [CNT_W-1:0]      remaining;
    logic [ADDR_SIZE-1:0]  awaddr;
    logic [DATA_WIDTH-1:0] wdata;
    logic                  awvalid, wvalid, bready;

    logic s_ready_d, awvalid_d, wvalid_d, bready_d, done_d, busy_d;
    logic latch, capture, resp_ok, resp_err;

    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) state <= ST_IDLE;
        else          state <= state_d;
    end

    // Next state plus the next value of every registered output, so each
    // output is a flop that already reflects the state being entered.
    always_comb begin
        state_d   = state;
        s_ready_d = 1'b0;
        awvalid_d = 1'b0;
        wvalid_d  = 1'b0;
        bready_d  = 1'b0;
        done_d    = 1'b0;
        busy_d    = busy;
        latch     = 1'b0;
        capture   = 1'b0;
        resp_ok   = 1'b0;
        resp_err  = 1'b0;
        unique case (state)
            ST_IDLE: begin
                if (start) begin
                    latch  = 1'b1;
                    busy_d = 1'b1;
                    if (word_count != '0) begin
                        state_d   = ST_FETCH;
                        s_ready_d = 1'b1;
                    end else begin
                        state_d = ST_FIN;
                        done_d  = 1'b1;
                    end
                end
            end
            ST_FETCH: begin
                s_ready_d = 1'b1;
                if (s_valid && s_ready) begin
                    capture   = 1'b1;
                    s_ready_d = 1'b0;
                    awvalid_d = 1'b1;
                    wvalid_d  = 1'b1;
                    state_d   = ST_ISSUE;
                end
            end
            ST_ISSUE: begin
                // AW and W retire independently; leave once both are gone.
                awvalid_d = awvalid & ~axi.awready;
                wvalid_d  = wvalid & ~axi.wready;
                if (!awvalid_d && !wvalid_d) begin
                    state_d  = ST_RESP;
                    bready_d = 1'b1;
                end
            end
            ST_RESP: begin
                bready_d = 1'b1;
                if (axi.bvalid) begin
                    bready_d = 1'b0;
                    if (axi.bresp != RESP_OKAY) begin
                        resp_err = 1'b1;
                        state_d  = ST_FIN;
                        done_d   = 1'b1;
                    end else begin
                        resp_ok = 1'b1;
                        if (remaining == CNT_W'(1)) begin
                            state_d = ST_FIN;
                            done_d  = 1'b1;
                        end else begin
                            state_d   = ST_FETCH;
                            s_ready_d = 1'b1;
                        end
                    end
                end
            end
            ST_FIN: begin
                busy_d  = 1'b0;
                state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            s_ready   <= 1'b0;
            awvalid   <= 1'b0;
            wvalid    <= 1'b0;
            bready    <= 1'b0;
            done      <= 1'b0;
            busy      <= 1'b0;
            err       <= 1'b0;
            err_addr  <= '0;
            addr      <= '0;
            remaining <= '0;
            awaddr    <= '0;
            wdata     <= '0;
        end else begin
            s_ready <= s_ready_d;
            awvalid <= awvalid_d;
            wvalid  <= wvalid_d;
            bready  <= bready_d;
            done    <= done_d;
            busy    <= busy_d;
            if (latch) begin
                addr      <= base_addr;
                remaining <= word_count;
                err       <= 1'b0;
                err_addr  <= '0;
            end
            if (capture) begin
                awaddr <= addr;
                wdata  <= s_data;
            end
            // Address wraps silently at the top of the address space.
            if (resp_ok) begin
                addr      <= addr + ADDR_SIZE'(NUM_STROBE);
                remaining <= remaining - CNT_W'(1);
            end
            if (resp_err) begin
                err      <= 1'b1;
                err_addr <= addr;
            end
        end
    end

    assign axi.awaddr  = awaddr;
    assign axi.awvalid = awvalid;
    assign axi.wdata   = wdata;
    assign axi.wstrb   = '1;
    assign axi.wvalid  = wvalid;
    assign axi.bready  = bready;

endmodule

// File: tb/tb_cell_axilite_param_loader.sv
// Self-checking bench for cell_axilite_param_loader: a source model, an
// AXI-lite slave model with programmable AW/W stall and error injection,
// and directed plus randomized commands checked against expected write lists.
module tb_cell_axilite_param_loader;
    import cell_axi_pkg::*;

    localparam int AW = 32;
    localparam int DW = 32;
    localparam int CW = 8;

    logic          aclk = 1'b0;
    logic          aresetn = 1'b1;
    logic          start;
    logic [AW-1:0] base_addr;
    logic [CW-1:0] word_count;
    logic [DW-1:0] s_data;
    logic          s_valid, s_ready, busy, done, err;
    logic [AW-1:0] err_addr;

    always #5 aclk = ~aclk;

    cell_axilite_param_loader_if #(.ADDR_SIZE(AW), .DATA_WIDTH(DW)) bus ();

    cell_axilite_param_loader #(.ADDR_SIZE(AW), .DATA_WIDTH(DW), .CNT_W(CW)) dut (
        .aclk(aclk), .aresetn(aresetn), .start(start), .base_addr(base_addr),
        .word_count(word_count), .s_data(s_data), .s_valid(s_valid),
        .s_ready(s_ready), .busy(busy), .done(done), .err(err),
        .err_addr(err_addr), .axi(bus.master)
    );

    int total = 0;
    int bad   = 0;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // ---------------- source model ----------------
    logic [DW-1:0] src_mem [0:1023];
    int  src_wr = 0;
    int  src_rd = 0;
    int  nr;
    bit  src_gap = 0;

    always @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            s_valid <= 1'b0;
            s_data  <= '0;
        end else begin
            nr = src_rd + ((s_valid && s_ready) ? 1 : 0);
            src_rd  <= nr;
            s_valid <= (nr < src_wr) && (!src_gap || ($urandom_range(0, 1) == 1));
            s_data  <= src_mem[nr % 1024];
        end
    end

    // ---------------- slave model ----------------
    int aw_dly = 0, w_dly = 0;
    int aw_cnt, w_cnt;
    int b_cnt = 0;
    int err_at = -1;
    int viol = 0;
    bit aw_pend, w_pend, aw_hs, w_hs, a_nx, w_nx;
    logic          p_awv, p_awr, p_wv, p_wr;
    logic [AW-1:0] p_awaddr;
    logic [DW-1:0] p_wdata;
    logic [AW-1:0] aw_log [$];
    logic [DW-1:0] w_log  [$];

    assign bus.awready = (aw_cnt >= aw_dly);
    assign bus.wready  = (w_cnt >= w_dly);

    always @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            aw_cnt <= 0; w_cnt <= 0; aw_pend <= 1'b0; w_pend <= 1'b0;
            bus.bvalid <= 1'b0; bus.bresp <= RESP_OKAY;
            p_awv <= 1'b0; p_awr <= 1'b0; p_wv <= 1'b0; p_wr <= 1'b0;
            p_awaddr <= '0; p_wdata <= '0;
        end else begin
            aw_hs = bus.awvalid && bus.awready;
            w_hs  = bus.wvalid && bus.wready;
            if (aw_hs) begin
                aw_log.push_back(bus.awaddr);
                aw_cnt <= 0;
                if (aw_pend) viol++;
            end else if (bus.awvalid) aw_cnt <= aw_cnt + 1;
            if (w_hs) begin
                w_log.push_back(bus.wdata);
                w_cnt <= 0;
                if (w_pend) viol++;
                if (bus.wstrb !== 4'hF) viol++;
            end else if (bus.wvalid) w_cnt <= w_cnt + 1;
            // a valid that was stalled must stay up with the same payload
            if (p_awv && !p_awr && (!bus.awvalid || bus.awaddr !== p_awaddr)) viol++;
            if (p_wv && !p_wr && (!bus.wvalid || bus.wdata !== p_wdata)) viol++;
            p_awv <= bus.awvalid; p_awr <= bus.awready; p_awaddr <= bus.awaddr;
            p_wv  <= bus.wvalid;  p_wr  <= bus.wready;  p_wdata  <= bus.wdata;
            if (bus.bvalid && bus.bready) begin
                bus.bvalid <= 1'b0;
                aw_pend <= 1'b0;
                w_pend  <= 1'b0;
                b_cnt   <= b_cnt + 1;
            end else if (!bus.bvalid) begin
                a_nx = aw_pend || aw_hs;
                w_nx = w_pend || w_hs;
                aw_pend <= a_nx;
                w_pend  <= w_nx;
                if (a_nx && w_nx) begin
                    bus.bvalid <= 1'b1;
                    bus.bresp  <= (b_cnt == err_at) ? RESP_SLVERR : RESP_OKAY;
                end
            end
        end
    end

    // One command: e = index of the write answered with SLVERR, or -1.
    // Expected behaviour: writes base+4*i of word i in order, stopping after
    // the failing write; done 3*writes+1 cycles after start with an ideal
    // slave and source.
    task automatic run_cmd(input string tag, input logic [AW-1:0] b, input int n,
                           input int e, input bit fixed_words);
        int a0, w0, r0, lat, nw;
        logic [DW-1:0] exp_w [$];
        logic [DW-1:0] wd;
        logic [AW-1:0] ea;
        bit ideal;
        ideal = (aw_dly == 0) && (w_dly == 0) && !src_gap;
        @(negedge aclk);
        a0 = aw_log.size();
        w0 = w_log.size();
        src_wr = src_rd;
        r0 = src_rd;
        // extra words beyond n show that nothing past the command is pulled
        for (int i = 0; i < n + 2; i++) begin
            wd = fixed_words ? (32'hA1 + 32'h11 * i) : $urandom;
            src_mem[(src_wr + i) % 1024] = wd;
            exp_w.push_back(wd);
        end
        src_wr = src_wr + n + 2;
        err_at = (e >= 0) ? b_cnt + e : -1;
        base_addr  = b;
        word_count = CW'(n);
        start = 1'b1;
        lat = 0;
        while (1) begin
            @(posedge aclk);
            lat++;
            #1;
            start = 1'b0;
            if (done || lat >= 400) break;
        end
        nw = (e >= 0 && e < n) ? e + 1 : n;
        chk({tag, ".done"}, done, 1'b1);
        if (ideal) chk({tag, ".latency"}, lat, 3 * nw + 1);
        chk({tag, ".busy_at_done"}, busy, 1'b1);
        chk({tag, ".err"}, err, (e >= 0 && e < n));
        chk({tag, ".err_addr"}, err_addr, (e >= 0 && e < n) ? b + AW'(4 * e) : '0);
        @(posedge aclk);
        #1;
        chk({tag, ".done_pulse"}, done, 1'b0);
        chk({tag, ".busy_low"}, busy, 1'b0);
        repeat (3) @(posedge aclk);
        #1;
        chk({tag, ".fetched"}, src_rd - r0, nw);
        chk({tag, ".aw_count"}, aw_log.size() - a0, nw);
        chk({tag, ".w_count"}, w_log.size() - w0, nw);
        for (int i = 0; i < nw && a0 + i < aw_log.size() && w0 + i < w_log.size(); i++) begin
            ea = b + AW'(4 * i);
            chk($sformatf("%s.addr%0d", tag, i), aw_log[a0 + i], ea);
            chk($sformatf("%s.data%0d", tag, i), w_log[w0 + i], exp_w[i]);
        end
    endtask

    initial begin
        int n, e, k;
        logic [AW-1:0] b;
        start = 1'b0;
        base_addr = '0;
        word_count = '0;
        #1 aresetn = 1'b0;
        repeat (3) @(posedge aclk);
        @(negedge aclk);
        chk("rst.s_ready", s_ready, 1'b0);
        chk("rst.busy", busy, 1'b0);
        chk("rst.done", done, 1'b0);
        chk("rst.err", err, 1'b0);
        chk("rst.err_addr", err_addr, '0);
        chk("rst.awvalid", bus.awvalid, 1'b0);
        chk("rst.wvalid", bus.wvalid, 1'b0);
        chk("rst.bready", bus.bready, 1'b0);
        chk("rst.awaddr", bus.awaddr, '0);
        chk("rst.wdata", bus.wdata, '0);
        chk("rst.wstrb", bus.wstrb, 4'hF);
        aresetn = 1'b1;
        repeat (2) @(posedge aclk);

        run_cmd("basic", 32'h10, 3, -1, 1'b1);
        aw_dly = 4;
        run_cmd("aw_late", 32'h100, 2, -1, 1'b0);
        aw_dly = 0;
        w_dly = 3;
        run_cmd("w_late", 32'h180, 2, -1, 1'b0);
        w_dly = 0;
        run_cmd("zero", 32'h40, 0, -1, 1'b0);
        run_cmd("slverr", 32'h200, 3, 1, 1'b0);
        run_cmd("after_err", 32'h300, 1, -1, 1'b0);
        run_cmd("wrap", 32'hFFFF_FFFC, 2, -1, 1'b0);

        // asynchronous reset while a write address is stalled
        aw_dly = 50;
        @(negedge aclk);
        src_wr = src_rd;
        src_mem[src_wr % 1024] = 32'h1234;
        src_wr = src_wr + 1;
        base_addr = 32'h500;
        word_count = 8'd3;
        start = 1'b1;
        @(negedge aclk);
        start = 1'b0;
        k = 0;
        while (!bus.awvalid && k < 20) begin
            @(negedge aclk);
            k++;
        end
        chk("rst_mid.awvalid_seen", bus.awvalid, 1'b1);
        #2 aresetn = 1'b0;
        #1;
        chk("rst_mid.awvalid", bus.awvalid, 1'b0);
        chk("rst_mid.wvalid", bus.wvalid, 1'b0);
        chk("rst_mid.bready", bus.bready, 1'b0);
        chk("rst_mid.busy", busy, 1'b0);
        @(negedge aclk);
        aresetn = 1'b1;
        aw_dly = 0;
        run_cmd("post_rst", 32'h600, 2, -1, 1'b0);

        // randomized commands
        for (int it = 0; it < 10; it++) begin
            b = $urandom & 32'hFFFF_FFFC;
            n = $urandom_range(1, 6);
            e = ($urandom_range(0, 1) == 1) ? $urandom_range(0, n - 1) : -1;
            aw_dly = $urandom_range(0, 3);
            w_dly = $urandom_range(0, 3);
            src_gap = ($urandom_range(0, 2) == 0);
            run_cmd($sformatf("rnd%0d", it), b, n, e, 1'b0);
        end
        src_gap = 1'b0;
        chk("protocol", viol, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
